// File: rtl/uart_pkg.sv
// Shared UART definitions: frame size and the state encoding
// used by both the transmitter and the receiver.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_IDX_W     = $clog2(UART_DATA_BITS);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      CLEANUP = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
// Every output comes straight from a flop.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       i_Clock,
   input  logic       i_Rst_L,
   input  logic       i_TX_DV,
   input  logic [7:0] i_TX_Byte,
   output logic       o_TX_Active,
   output logic       o_TX_Serial,
   output logic       o_TX_Done
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);

   // Last count of a full bit period.
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   // The stop level lasts STOP plus the one CLEANUP cycle, so STOP
   // ends one count early; Done then lands exactly 10 bit periods
   // after the start edge and the next byte can be taken one cycle later.
   localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);

   localparam logic [UART_IDX_W-1:0] IDX_LAST = UART_IDX_W'(UART_DATA_BITS - 1);

   uart_state_e state_q, state_n;

   logic [CW-1:0]         cnt_q, cnt_n;
   logic [UART_IDX_W-1:0] idx_q, idx_n;
   logic [7:0]            byte_q, byte_n;
   logic                  ser_q, ser_n;
   logic                  act_q, act_n;
   logic                  done_q, done_n;

   // Next-state, counter and output logic for the frame sequencer.
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      idx_n   = idx_q;
      byte_n  = byte_q;
      ser_n   = ser_q;
      act_n   = act_q;
      done_n  = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_n = '0;
            idx_n = '0;
            ser_n = 1'b1;
            act_n = 1'b0;
            if (i_TX_DV) begin
               byte_n  = i_TX_Byte;
               act_n   = 1'b1;
               ser_n   = 1'b0;
               state_n = START;
            end
         end

         START: begin
            if (cnt_q == BIT_LAST) begin
               cnt_n   = '0;
               ser_n   = byte_q[0];
               state_n = DATA;
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end

         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_n = '0;
               if (idx_q == IDX_LAST) begin
                  idx_n   = '0;
                  ser_n   = 1'b1;
                  state_n = STOP;
               end else begin
                  idx_n = idx_q + UART_IDX_W'(1);
                  ser_n = byte_q[idx_n];
               end
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end

         STOP: begin
            if (cnt_q == STOP_LAST) begin
               cnt_n   = '0;
               state_n = CLEANUP;
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end

         CLEANUP: begin
            done_n  = 1'b1;
            act_n   = 1'b0;
            ser_n   = 1'b1;
            state_n = IDLE;
         end

         default: begin
            cnt_n   = '0;
            idx_n   = '0;
            ser_n   = 1'b1;
            act_n   = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge i_Clock) begin
      if (!i_Rst_L) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         byte_q  <= '0;
         ser_q   <= 1'b1;
         act_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         idx_q   <= idx_n;
         byte_q  <= byte_n;
         ser_q   <= ser_n;
         act_q   <= act_n;
         done_q  <= done_n;
      end
   end

   assign o_TX_Serial = ser_q;
   assign o_TX_Active = act_q;
   assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed and random checks of uart_tx against a frame-level model,
// plus a loopback through a behavioural mid-bit sampling receiver.
module tb_uart_tx;

   localparam int CPB  = 4;
   localparam int CPBL = 87;
   localparam int PER  = 10;

   logic       clk = 1'b0;
   logic       rst_l;

   logic       dv4, act4, ser4, done4;
   logic [7:0] byte4;
   logic       dv87, act87, ser87, done87;
   logic [7:0] byte87;

   int n_chk  = 0;
   int n_fail = 0;

   time t_fall;
   time t_prev;

   uart_tx #(.CLKS_PER_BIT(CPB)) dut4 (
      .i_Clock     (clk),
      .i_Rst_L     (rst_l),
      .i_TX_DV     (dv4),
      .i_TX_Byte   (byte4),
      .o_TX_Active (act4),
      .o_TX_Serial (ser4),
      .o_TX_Done   (done4)
   );

   uart_tx #(.CLKS_PER_BIT(CPBL)) dut87 (
      .i_Clock     (clk),
      .i_Rst_L     (rst_l),
      .i_TX_DV     (dv87),
      .i_TX_Byte   (byte87),
      .o_TX_Active (act87),
      .o_TX_Serial (ser87),
      .o_TX_Done   (done87)
   );

   always #(PER / 2) clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle4(input string tag);
      chk({tag, "_ser"}, 32'(ser4), 32'd1);
      chk({tag, "_act"}, 32'(act4), 32'd0);
      chk({tag, "_done"}, 32'(done4), 32'd0);
   endtask

   // Send one byte on dut4 and check the whole frame cycle by cycle.
   // Extra strobes of 0xFF are sampled at edges t0+e1 and t0+e2.
   // Returns just after edge t0+10*CPB with Done checked high.
   task automatic frame4(input logic [7:0] b, input int e1, input int e2);
      logic [9:0] bits;
      bits  = {1'b1, b, 1'b0};
      byte4 = b;
      dv4   = 1'b1;
      tick();
      dv4    = 1'b0;
      t_fall = $time;
      for (int k = 0; k < 10 * CPB; k++) begin
         chk("frame_ser", 32'(ser4), 32'(bits[k / CPB]));
         chk("frame_act", 32'(act4), 32'd1);
         chk("frame_done", 32'(done4), 32'd0);
         byte4 = 8'($urandom);
         if (k + 1 == e1 || k + 1 == e2) begin
            dv4   = 1'b1;
            byte4 = 8'hFF;
         end
         tick();
         dv4 = 1'b0;
      end
      chk("end_done", 32'(done4), 32'd1);
      chk("end_act", 32'(act4), 32'd0);
      chk("end_ser", 32'(ser4), 32'd1);
   endtask

   // Send one byte on dut87 and recover it by sampling mid-bit.
   task automatic loop87(input logic [7:0] b);
      logic [7:0] rx;
      int         dones;
      int         j;
      rx     = '0;
      dones  = 0;
      byte87 = b;
      dv87   = 1'b1;
      tick();
      dv87 = 1'b0;
      for (int k = 0; k <= 10 * CPBL; k++) begin
         if (k % CPBL == CPBL / 2) begin
            j = k / CPBL;
            if (j == 0)
               chk("rx_start", 32'(ser87), 32'd0);
            else if (j <= 8)
               rx[j-1] = ser87;
            else
               chk("rx_stop", 32'(ser87), 32'd1);
         end
         if (done87) dones++;
         if (k < 10 * CPBL) tick();
      end
      chk("rx_byte", 32'(rx), 32'(b));
      chk("rx_dv_count", 32'(dones), 32'd1);
   endtask

   initial begin
      logic [9:0] bits;
      logic [7:0] r;

      rst_l  = 1'b0;
      dv4    = 1'b0;
      byte4  = '0;
      dv87   = 1'b0;
      byte87 = '0;
      tick();
      tick();
      chk_idle4("reset4");
      chk("reset87_ser", 32'(ser87), 32'd1);
      chk("reset87_act", 32'(act87), 32'd0);
      rst_l = 1'b1;

      // Idle line after reset release.
      for (int i = 0; i < 100; i++) begin
         tick();
         chk_idle4("idle");
      end

      // Basic frame.
      frame4(8'hA5, -1, -1);
      tick();
      chk_idle4("after_a5");

      // Strobes mid-frame and in the last cycle are dropped.
      frame4(8'h00, 5, 40);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk_idle4("after_drop");
      end

      // Reset mid-frame abandons the frame.
      bits  = {1'b1, 8'h3C, 1'b0};
      byte4 = 8'h3C;
      dv4   = 1'b1;
      tick();
      dv4 = 1'b0;
      for (int k = 0; k < 17; k++) begin
         chk("pre_rst_ser", 32'(ser4), 32'(bits[k / CPB]));
         tick();
      end
      rst_l = 1'b0;
      tick();
      rst_l = 1'b1;
      chk_idle4("mid_rst");
      for (int i = 0; i < 50; i++) begin
         tick();
         chk_idle4("post_rst");
      end
      frame4(8'($urandom), -1, -1);
      tick();

      // Reset and strobe together: reset wins.
      rst_l = 1'b0;
      dv4   = 1'b1;
      byte4 = 8'h81;
      tick();
      rst_l = 1'b0;
      dv4   = 1'b0;
      tick();
      rst_l = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_idle4("rst_vs_dv");
      end

      // Back-to-back frames.
      frame4(8'h55, -1, -1);
      t_prev = t_fall;
      frame4(8'hAA, -1, -1);
      chk("b2b_spacing", 32'((t_fall - t_prev) / PER),
          32'(10 * CPB + 1));
      t_prev = t_fall;
      r = 8'($urandom);
      frame4(r, -1, -1);
      chk("b2b_spacing2", 32'((t_fall - t_prev) / PER),
          32'(10 * CPB + 1));
      tick();

      // Random bytes with random idle gaps.
      for (int i = 0; i < 16; i++) begin
         frame4(8'($urandom), -1, -1);
         tick();
         chk("rand_done_clr", 32'(done4), 32'd0);
         repeat ($urandom_range(0, 5)) tick();
      end

      // Loopback at the default bit period.
      loop87(8'h00);
      loop87(8'hFF);
      for (int i = 0; i < 38; i++)
         loop87(8'($urandom));
      tick();
      chk("loop_idle_ser", 32'(ser87), 32'd1);
      chk("loop_idle_act", 32'(act87), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
